// File: rtl/mul_seq.sv
// Shift-and-add multiplier controller driving the shared 16-bit ALU one op per cycle.
// Optional operand ordering (smaller operand drives the loop) enabled by MUL_SEQ_SWAP_EN.
module mul_seq #(
    parameter int N = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [N-1:0] i_mcand,
    input  logic [N-1:0] i_mplier,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_product,
    output logic [N-1:0] o_alu_a,
    output logic [N-1:0] o_alu_b,
    output logic [1:0]   o_alu_ctrl,
    input  logic [N-1:0] i_alu_q,
    input  logic         i_alu_mayor
);

    localparam logic [1:0] CTRL_ADD = 2'b00;
    localparam logic [1:0] CTRL_SHL = 2'b11;
    localparam logic [1:0] CTRL_SHR = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TEST,
        S_ADD,
        S_SHL,
        S_SHR,
        S_DONE
`ifdef MUL_SEQ_SWAP_EN
        , S_CMP
`endif
    } state_e;

    state_e       state_q, state_d;
    logic [N-1:0] acc_q, acc_d;
    logic [N-1:0] mc_q, mc_d;
    logic [N-1:0] mp_q, mp_d;
    logic [N-1:0] product_q, product_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

`ifndef MUL_SEQ_SWAP_EN
    logic unused_mayor;
    assign unused_mayor = i_alu_mayor;
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mc_d      = mc_q;
        mp_d      = mp_q;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    mc_d  = i_mcand;
                    mp_d  = i_mplier;
                    acc_d = '0;
`ifdef MUL_SEQ_SWAP_EN
                    state_d = S_CMP;
`else
                    state_d = S_TEST;
`endif
                end
            end
`ifdef MUL_SEQ_SWAP_EN
            S_CMP: begin
                // mc <= mp: swap so the smaller operand ends up in mp
                if (!i_alu_mayor) begin
                    mc_d = mp_q;
                    mp_d = mc_q;
                end
                state_d = S_TEST;
            end
`endif
            S_TEST: begin
                if (mp_q == '0) begin
                    product_d = acc_q;
                    state_d   = S_DONE;
                end else if (mp_q[0]) begin
                    state_d = S_ADD;
                end else begin
                    state_d = S_SHL;
                end
            end
            S_ADD: begin
                acc_d   = i_alu_q;
                state_d = S_SHL;
            end
            S_SHL: begin
                mc_d    = i_alu_q;
                state_d = S_SHR;
            end
            S_SHR: begin
                mp_d    = i_alu_q;
                state_d = S_TEST;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // ALU drive is combinational so the result returns within the same cycle
    always_comb begin
        o_alu_a    = '0;
        o_alu_b    = '0;
        o_alu_ctrl = CTRL_ADD;
        case (state_q)
`ifdef MUL_SEQ_SWAP_EN
            S_CMP: begin
                o_alu_a = mc_q;
                o_alu_b = mp_q;
            end
`endif
            S_ADD: begin
                o_alu_a = acc_q;
                o_alu_b = mc_q;
            end
            S_SHL: begin
                o_alu_a    = mc_q;
                o_alu_ctrl = CTRL_SHL;
            end
            S_SHR: begin
                o_alu_a    = mp_q;
                o_alu_ctrl = CTRL_SHR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mc_q      <= '0;
            mp_q      <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mc_q      <= mc_d;
            mp_q      <= mp_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_product = product_q;

endmodule

// File: tb/tb_mul_seq.sv
// Randomized bench for mul_seq with a behavioural ALU and an arithmetic product/latency model.
module tb_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic [15:0] i_mcand, i_mplier;
    logic        o_busy, o_done;
    logic [15:0] o_product, o_alu_a, o_alu_b;
    logic [1:0]  o_alu_ctrl;
    logic [15:0] alu_q;
    logic        alu_mayor;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mul_seq #(.N(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start),
        .i_mcand(i_mcand), .i_mplier(i_mplier),
        .o_busy(o_busy), .o_done(o_done), .o_product(o_product),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_ctrl(o_alu_ctrl),
        .i_alu_q(alu_q), .i_alu_mayor(alu_mayor)
    );

    // shared ALU behaviour
    always_comb begin
        alu_q     = 16'h0;
        alu_mayor = 1'b0;
        case (o_alu_ctrl)
            2'b00: begin
                alu_q     = o_alu_a + o_alu_b;
                alu_mayor = (o_alu_a > o_alu_b);
            end
            2'b11: alu_q = o_alu_a << 1;
            2'b01: alu_q = o_alu_a >> 1;
            default: alu_q = 16'h0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_prod(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        return p[15:0];
    endfunction

    // edges from the start-sampling edge until DONE is visible
    function automatic int ref_cycles(input logic [15:0] a, input logic [15:0] b);
        int c;
        logic [15:0] v;
`ifdef MUL_SEQ_SWAP_EN
        v = (a < b) ? a : b;
        c = 1;
`else
        v = b;
        c = 0;
        if (a == 16'hFFFF && a == 16'h0) c = 99;
`endif
        while (v != 0) begin
            c += v[0] ? 4 : 3;
            v = v >> 1;
        end
        return c + 1;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(o_busy), 0);
        chk({tag, "_done"}, 32'(o_done), 0);
        chk({tag, "_prod"}, 32'(o_product), 0);
        chk({tag, "_alu"}, {o_alu_a, o_alu_b} | 32'(o_alu_ctrl), 0);
    endtask

    // glitch: pulse a 9x9 start mid-run; hold: keep i_start high through DONE
    task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input string tag,
                           input bit glitch, input bit hold);
        int cyc;
        @(negedge clk);
        i_start = 1'b1; i_mcand = a; i_mplier = b;
        @(posedge clk); #1;
        if (!hold) i_start = 1'b0;
        chk({tag, "_busy_rise"}, 32'(o_busy), 1);
        cyc = 0;
        while (!o_done && cyc < 200) begin
            if (glitch && cyc == 3) begin
                i_start = 1'b1; i_mcand = 16'd9; i_mplier = 16'd9;
            end else if (glitch && cyc == 4) begin
                i_start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_lat"}, 32'(cyc), 32'(ref_cycles(a, b)));
        chk({tag, "_prod"}, 32'(o_product), 32'(ref_prod(a, b)));
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(o_done), 0);
        chk({tag, "_idle"}, 32'(o_busy), 0);
    endtask

    initial begin
        logic [31:0] r;
        logic [15:0] ra, rb;
        logic [1:0]  ctrl_seq [$];
        logic [1:0]  exp_seq  [$];
        int          add_idx;
        rst_n = 1'b0; i_start = 1'b0; i_mcand = '0; i_mplier = '0;
        repeat (2) @(posedge clk);
        #1 chk_reset_vals("rst");
        @(negedge clk) rst_n = 1'b1;

        run_mul(16'd3, 16'd5, "b3x5", 0, 0);

        // reset mid-operation at edge 4
        @(negedge clk);
        i_start = 1'b1; i_mcand = 16'd3; i_mplier = 16'd5;
        @(posedge clk); #1 i_start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_reset_vals("midrst");
        @(posedge clk); #1 chk("midrst_nodone", 32'(o_done), 0);
        @(negedge clk) rst_n = 1'b1;
        run_mul(16'd2, 16'd2, "r2x2", 0, 0);

`ifdef MUL_SEQ_SWAP_EN
        run_mul(16'd0, 16'd7, "z0x7", 0, 0);
`else
        run_mul(16'd7, 16'd0, "z7x0", 0, 0);
`endif
        run_mul(16'h0100, 16'h0100, "wrap1", 0, 0);
        run_mul(16'hFFFF, 16'h0002, "wrap2", 0, 0);
        run_mul(16'd6, 16'd7, "ign", 1, 0);

        // start held through DONE: next acceptance is the first IDLE edge
        run_mul(16'd4, 16'd3, "hold", 0, 1);
        @(posedge clk); #1;
        chk("hold_reaccept", 32'(o_busy), 1);
        i_start = 1'b0;
        for (int k = 0; k < 200 && !o_done; k++) begin
            @(posedge clk); #1;
        end
        chk("hold_prod2", 32'(o_product), 32'(ref_prod(16'd4, 16'd3)));
        @(posedge clk); #1;

        // ALU drive sequence for 1x1
`ifdef MUL_SEQ_SWAP_EN
        exp_seq = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00};
        add_idx = 2;
`else
        exp_seq = '{2'b00, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00};
        add_idx = 1;
`endif
        @(negedge clk);
        i_start = 1'b1; i_mcand = 16'd1; i_mplier = 16'd1;
        @(posedge clk); #1 i_start = 1'b0;
        for (int k = 0; k < exp_seq.size(); k++) begin
            ctrl_seq.push_back(o_alu_ctrl);
            if (k == add_idx) chk("drv_add_ab", {o_alu_a, o_alu_b}, {16'd0, 16'd1});
            if (k == exp_seq.size() - 1) chk("drv_done", 32'(o_done), 1);
            @(posedge clk); #1;
        end
        for (int k = 0; k < exp_seq.size(); k++)
            chk($sformatf("drv_ctrl%0d", k), 32'(ctrl_seq[k]), 32'(exp_seq[k]));

        for (int t = 0; t < 24; t++) begin
            r  = $urandom;
            ra = r[15:0];
            r  = $urandom;
            rb = r[15:0] >> $urandom_range(0, 15);
            if (t % 3 == 1) begin
                logic [15:0] tmp;
                tmp = ra; ra = rb; rb = tmp;
            end
            run_mul(ra, rb, $sformatf("rnd%0d", t), 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mul_seq.md
# mul_seq

Sequential shift-and-add multiplier controller that sits directly upstream of the shared 16-bit ALU. It accepts two operands on a start pulse and drives the ALU's `a`/`b`/`control` inputs one operation per cycle: add (`00`), shift left (`11`), shift right (`01`). It consumes the ALU result `q` and greater-than flag `mayor`, and returns the low N bits of the product with a one-cycle done pulse.

## Interface
- `N`, 16, operand, ALU and product width
- `i_clk`  in  1  clock, rising edge
- `i_rst_n`  in  1  reset, asynchronous, active-low
- `i_start`  in  1  start request, sampled only in IDLE
- `i_mcand`  in  N  multiplicand, latched on accepted start
- `i_mplier`  in  N  multiplier, latched on accepted start
- `o_busy`  out  1  high in every state except IDLE
- `o_done`  out  1  one-cycle pulse, high in DONE
- `o_product`  out  N  product mod 2^N, updated on entry to DONE, held until next DONE
- `o_alu_a`  out  N  to ALU `a`
- `o_alu_b`  out  N  to ALU `b`
- `o_alu_ctrl`  out  2  to ALU control
- `i_alu_q`  in  N  from ALU result
- `i_alu_mayor`  in  1  from ALU greater-than flag; valid only when control is `00`

## Operation
- Registers:
  - `acc`: accumulator.
  - `mc`: multiplicand, shifted left each iteration.
  - `mp`: multiplier, shifted right each iteration.
- States: IDLE, CMP (present only with the macro), TEST, ADD, SHL, SHR, DONE.
- IDLE:
  - On `i_start`=1: `mc`<=`i_mcand`, `mp`<=`i_mplier`, `acc`<=0.
  - Next state is CMP, or TEST if CMP is compiled out.
- CMP:
  - Drive a=`mc`, b=`mp`, ctrl=`00`.
  - If `i_alu_mayor`=0 (mc <= mp), swap `mc` and `mp`.
  - Next state: TEST.
- TEST (ALU idle-driven):
  - `mp`==0 -> DONE.
  - Otherwise `mp[0]`=1 -> ADD, else -> SHL.
- ADD: a=`acc`, b=`mc`, ctrl=`00`; `acc`<=`i_alu_q`; next state SHL.
- SHL: a=`mc`, ctrl=`11`; `mc`<=`i_alu_q`; next state SHR.
- SHR: a=`mp`, ctrl=`01`; `mp`<=`i_alu_q`; next state TEST.
- DONE: `o_done`=1; next state IDLE.
- Idle drive: in IDLE, TEST and DONE the ALU outputs are a=0, b=0, ctrl=`00`. In SHL and SHR, b=0.
- All arithmetic is N-bit. Carries and bits shifted out are discarded, so the product wraps mod 2^N and no overflow flag is produced.
- `i_start` outside IDLE, including in DONE, is ignored. Operands are never re-sampled mid-operation.

## Timing
- Reset values:
  - `o_busy`=0, `o_done`=0, `o_product`=0.
  - `o_alu_a`=0, `o_alu_b`=0, `o_alu_ctrl`=`00`.
  - state=IDLE; `acc`, `mc`, `mp` = 0.
- Reset asserted mid-operation aborts immediately to the reset values. No done pulse is produced.
- Let edge 0 be the clock edge that samples `i_start` in IDLE. `o_busy` rises after edge 0.
- State counts after edge 0:
  - 1 state for CMP (if present).
  - Per iteration: 4 states if `mp[0]`=1, 3 states if `mp[0]`=0.
  - 1 final TEST.
- DONE follows those states. IDLE follows DONE, and `o_busy` falls then.
- A new start is accepted on the first edge in IDLE after DONE.
- ALU outputs are combinational from the state and registers. The ALU result is captured at the end of the same cycle (single-cycle ALU path).

## Configuration
- `MUL_SEQ_SWAP_EN` defined:
  - CMP state present.
  - Operands are ordered so the smaller value drives the loop.
  - Adds 1 cycle of latency but cuts the iterations to bit-length(min operand).
- `MUL_SEQ_SWAP_EN` undefined:
  - No CMP state; IDLE goes directly to TEST.
  - `i_alu_mayor` is unused.
  - Iterations = bit-length(`i_mplier`).

## Test plan
- Reset mid-operation: start 3x5, assert `i_rst_n`=0 at edge 4 -> all outputs return to reset values at once, no `o_done`, and a fresh start of 2x2 gives `o_product`=4.
- Basic product 3x5:
  - Without macro: DONE after edge 12.
  - With macro: swap occurs and DONE after edge 10.
  - Either build: `o_product`=15, `o_done` high exactly 1 cycle.
- Zero operand:
  - 7x0 without macro: DONE after edge 1, product 0.
  - 0x7 with macro: swap, DONE after edge 2, product 0.
- Wrap-around: 0x0100 x 0x0100 -> `o_product`=0x0000; 0xFFFF x 0x0002 -> 0xFFFE.
- Ignored start:
  - Pulse `i_start` with 9x9 while busy on 6x7 -> result 42 and no restart.
  - `i_start` held high through DONE -> next accepted start is on the edge after DONE.
- ALU drive check: for 1x1, the ctrl sequence per cycle is [`00` CMP if enabled], `00` TEST, `00` ADD, `11` SHL, `01` SHR, `00` TEST, `00` DONE. ADD has a=0, b=1.
